// File: rtl/n101_subsys_amo_initr_pkg.sv
// Shared definitions for the AMO initiator: op encodings, FSM states and ICB size code.
package n101_subsys_amo_initr_pkg;

  typedef enum logic [2:0] {
    AMO_SWAP = 3'd0,
    AMO_ADD  = 3'd1,
    AMO_AND  = 3'd2,
    AMO_OR   = 3'd3,
    AMO_XOR  = 3'd4,
    AMO_MAX  = 3'd5,
    AMO_MIN  = 3'd6,
    AMO_MAXU = 3'd7
  } amo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LR_CMD = 3'd1,
    ST_LR_RSP = 3'd2,
    ST_SC_CMD = 3'd3,
    ST_SC_RSP = 3'd4,
    ST_DONE   = 3'd5
  } amo_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/n101_subsys_amo_initr_alu.sv
// Combinational AMO operation: new value from op, old memory value and operand.
module n101_amo_alu
  import n101_subsys_amo_initr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = operand_i;
    case (amo_op_e'(op_i))
      AMO_SWAP: new_o = operand_i;
      AMO_ADD:  new_o = old_i + operand_i;
      AMO_AND:  new_o = old_i & operand_i;
      AMO_OR:   new_o = old_i | operand_i;
      AMO_XOR:  new_o = old_i ^ operand_i;
      AMO_MAX:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
      AMO_MIN:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
      AMO_MAXU: new_o = (old_i > operand_i) ? old_i : operand_i;
    endcase
  end

endmodule

// File: rtl/n101_subsys_amo_initr.sv
// Atomic memory operation initiator: performs an LR/SC loop on the ICB bus with bounded retries.
// state     | meaning
// IDLE      | waiting for a request, req_ready high
// LR_CMD    | exclusive read command presented
// LR_RSP    | waiting for the read response (old value)
// SC_CMD    | exclusive write of the new value presented
// SC_RSP    | waiting for the write response; retry on excl failure
// DONE      | completion presented on rsp_*
module n101_subsys_amo_initr
  import n101_subsys_amo_initr_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int XLEN      = 32,
  parameter int MAX_RETRY = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [2:0]           req_op,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 o_icb_cmd_valid,
  input  logic                 o_icb_cmd_ready,
  output logic [ADDR_SIZE-1:0] o_icb_cmd_addr,
  output logic                 o_icb_cmd_read,
  output logic [XLEN-1:0]      o_icb_cmd_wdata,
  output logic [XLEN/8-1:0]    o_icb_cmd_wmask,
  output logic                 o_icb_cmd_lock,
  output logic                 o_icb_cmd_excl,
  output logic [1:0]           o_icb_cmd_size,
  input  logic                 o_icb_rsp_valid,
  output logic                 o_icb_rsp_ready,
  input  logic                 o_icb_rsp_err,
  input  logic                 o_icb_rsp_excl_ok,
  input  logic [XLEN-1:0]      o_icb_rsp_rdata
);

  localparam logic [7:0] MaxRetry = 8'(MAX_RETRY);

  amo_state_e           state_q;
  logic [7:0]           retry_q, retry_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [2:0]           op_q;
  logic [XLEN-1:0]      wdata_q, old_q, new_q, new_d;
  logic                 req_ready_q, rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]      rsp_rdata_q;
  logic                 cmd_valid_q, cmd_read_q, excl_q, lock_q, icb_rsp_ready_q;

  n101_amo_alu #(.XLEN(XLEN)) u_alu (
    .op_i      (op_q),
    .old_i     (o_icb_rsp_rdata),
    .operand_i (wdata_q),
    .new_o     (new_d)
  );

  // Saturation is implied: the counter only increments while below MAX_RETRY (<= 255).
  assign retry_d = retry_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      retry_q         <= '0;
      addr_q          <= '0;
      op_q            <= '0;
      wdata_q         <= '0;
      old_q           <= '0;
      new_q           <= '0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_read_q      <= 1'b0;
      excl_q          <= 1'b0;
      lock_q          <= 1'b0;
      icb_rsp_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          op_q        <= req_op;
          wdata_q     <= req_wdata;
          retry_q     <= '0;
          req_ready_q <= 1'b0;
          if (req_addr[1:0] != 2'b00) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= ST_LR_CMD;
            cmd_valid_q <= 1'b1;
            cmd_read_q  <= 1'b1;
            excl_q      <= 1'b1;
            lock_q      <= 1'b1;
          end
        end
        ST_LR_CMD: if (o_icb_cmd_ready) begin
          state_q         <= ST_LR_RSP;
          cmd_valid_q     <= 1'b0;
          icb_rsp_ready_q <= 1'b1;
        end
        ST_LR_RSP: if (o_icb_rsp_valid) begin
          icb_rsp_ready_q <= 1'b0;
          old_q           <= o_icb_rsp_rdata;
          if (o_icb_rsp_err) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= o_icb_rsp_rdata;
            lock_q      <= 1'b0;
            excl_q      <= 1'b0;
          end else begin
            state_q     <= ST_SC_CMD;
            new_q       <= new_d;
            cmd_valid_q <= 1'b1;
            cmd_read_q  <= 1'b0;
          end
        end
        ST_SC_CMD: if (o_icb_cmd_ready) begin
          state_q         <= ST_SC_RSP;
          cmd_valid_q     <= 1'b0;
          icb_rsp_ready_q <= 1'b1;
        end
        ST_SC_RSP: if (o_icb_rsp_valid) begin
          icb_rsp_ready_q <= 1'b0;
          if (!o_icb_rsp_err && !o_icb_rsp_excl_ok && (retry_q < MaxRetry)) begin
            state_q     <= ST_LR_CMD;
            retry_q     <= retry_d;
            cmd_valid_q <= 1'b1;
            cmd_read_q  <= 1'b1;
          end else begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= o_icb_rsp_err | ~o_icb_rsp_excl_ok;
            rsp_rdata_q <= old_q;
            lock_q      <= 1'b0;
            excl_q      <= 1'b0;
          end
        end
        ST_DONE: if (rsp_ready) begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_cmd_addr  = addr_q;
  assign o_icb_cmd_read  = cmd_read_q;
  assign o_icb_cmd_wdata = cmd_read_q ? '0 : new_q;
  assign o_icb_cmd_wmask = cmd_read_q ? '0 : {(XLEN/8){1'b1}};
  assign o_icb_cmd_lock  = lock_q;
  assign o_icb_cmd_excl  = excl_q;
  assign o_icb_cmd_size  = SIZE_WORD;
  assign o_icb_rsp_ready = icb_rsp_ready_q;

endmodule

// File: tb/tb_n101_subsys_amo_initr.sv
// Scoreboard bench for the AMO initiator with a behavioural ICB memory slave.
module tb_n101_subsys_amo_initr;

  localparam int MAXR = 2;
  localparam logic [2:0] OP_SWAP = 3'd0, OP_ADD = 3'd1, OP_MAX = 3'd5, OP_MIN = 3'd6, OP_MAXU = 3'd7;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cmd_valid, cmd_ready = 1'b0, cmd_read, cmd_lock, cmd_excl;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic [1:0]  cmd_size;
  logic        irsp_valid = 1'b0, irsp_ready, irsp_err = 1'b0, irsp_ok = 1'b0;
  logic [31:0] irsp_rdata = '0;

  n101_subsys_amo_initr #(.ADDR_SIZE(32), .XLEN(32), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_icb_cmd_valid(cmd_valid), .o_icb_cmd_ready(cmd_ready), .o_icb_cmd_addr(cmd_addr),
    .o_icb_cmd_read(cmd_read), .o_icb_cmd_wdata(cmd_wdata), .o_icb_cmd_wmask(cmd_wmask),
    .o_icb_cmd_lock(cmd_lock), .o_icb_cmd_excl(cmd_excl), .o_icb_cmd_size(cmd_size),
    .o_icb_rsp_valid(irsp_valid), .o_icb_rsp_ready(irsp_ready), .o_icb_rsp_err(irsp_err),
    .o_icb_rsp_excl_ok(irsp_ok), .o_icb_rsp_rdata(irsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    bit          chk_rdata;
    int          ncmd;
    logic [31:0] addr;
    logic [31:0] mem_after;
    bit          chk_mem;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, errors = 0;
  logic [31:0] mem[logic [31:0]];
  int          plan_fail = 0, cmd_count = 0;
  bit          plan_lr_err = 0, plan_sc_err = 0, hold_sc = 0, stray = 0;
  logic [31:0] exp_sc_wdata = '0, exp_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference semantics of each AMO written with plain integer arithmetic.
  function automatic logic [31:0] amo_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ua, ub;
    sa = a; sb = b; ua = longint'(a); ub = longint'(b);
    case (op)
      3'd0: return b;
      3'd1: return 32'((ua + ub) % 64'h1_0000_0000);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa >= sb) ? a : b;
      3'd6: return (sa <= sb) ? a : b;
      default: return (ua >= ub) ? a : b;
    endcase
  endfunction

  task automatic do_req(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] opd,
                        input logic [31:0] memval, input int fails, input bit lr_err,
                        input bit sc_err, input bit chk_lat);
    exp_t        e;
    logic [31:0] nv;
    int          t;
    nv = '0;
    e.addr = addr; e.chk_mem = 0; e.mem_after = '0;
    if (addr[1:0] != 2'b00) begin
      e.err = 1; e.rdata = '0; e.chk_rdata = 1; e.ncmd = 0;
    end else begin
      mem[addr] = memval;
      nv = amo_ref(op, memval, opd);
      e.chk_mem = 1; e.mem_after = memval; e.rdata = memval; e.chk_rdata = 1;
      if (lr_err) begin
        e.err = 1; e.chk_rdata = 0; e.ncmd = 1;
      end else if (sc_err) begin
        e.err = 1; e.ncmd = 2;
      end else if (fails > MAXR) begin
        e.err = 1; e.ncmd = 2 * (MAXR + 1);
      end else begin
        e.err = 0; e.ncmd = 2 * (fails + 1); e.mem_after = nv;
      end
    end
    plan_fail = fails; plan_lr_err = lr_err; plan_sc_err = sc_err;
    exp_sc_wdata = nv; exp_addr = addr;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1; req_addr = addr; req_op = op; req_wdata = opd;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 100);
    if (!req_ready) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    if (chk_lat) begin
      @(negedge clk);
      chk("misalign_rsp_latency", rsp_valid, 1);
    end
    t = 0;
    while (sbq.size() != 0 && t < 500) begin @(posedge clk); t++; end
    if (sbq.size() != 0) begin
      chk("rsp_timeout", 0, 1);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // Response monitor / scoreboard.
  initial begin : monitor
    exp_t        e;
    bit          hold;
    logic [32:0] held;
    hold = 0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) hold = 0;
      else begin
        if (hold) chk("rsp_stable", {rsp_err, rsp_rdata}, held);
        if (rsp_valid && rsp_ready) begin
          if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("rsp_err", rsp_err, e.err);
            if (e.chk_rdata) chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("icb_cmd_count", cmd_count, e.ncmd);
            if (e.chk_mem) chk("mem_after", mem_rd(e.addr), e.mem_after);
          end
          cmd_count = 0;
        end
        hold = rsp_valid && !rsp_ready;
        held = {rsp_err, rsp_rdata};
      end
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ICB memory slave with scripted exclusive-failure / error plan.
  initial begin : slave
    bit          cmd_hs, rsp_hs, pend, hold, stray_was;
    int          dly;
    bit          r_err, r_ok;
    logic [31:0] r_data, h_addr, h_wdata;
    logic [7:0]  h_ctl;
    pend = 0; hold = 0; stray_was = 0; dly = 0; r_err = 0; r_ok = 0; r_data = '0;
    h_addr = '0; h_wdata = '0; h_ctl = '0;
    forever begin
      @(negedge clk);
      cmd_hs = cmd_valid && cmd_ready && !rst;
      rsp_hs = irsp_valid && irsp_ready && !rst;
      if (hold && !rst) begin
        chk("cmd_addr_stable", cmd_addr, h_addr);
        chk("cmd_wdata_stable", cmd_wdata, h_wdata);
        chk("cmd_ctl_stable", {cmd_valid, cmd_read, cmd_wmask, cmd_excl, cmd_lock}, h_ctl);
      end
      hold = cmd_valid && !cmd_ready && !rst;
      h_addr = cmd_addr; h_wdata = cmd_wdata;
      h_ctl = {cmd_valid, cmd_read, cmd_wmask, cmd_excl, cmd_lock};
      if (cmd_hs) begin
        cmd_count++;
        chk("cmd_addr", cmd_addr, exp_addr);
        chk("cmd_excl", cmd_excl, 1);
        chk("cmd_size", cmd_size, 2'b10);
        if (cmd_read) begin
          chk("lr_wmask", cmd_wmask, 0);
          chk("lr_wdata", cmd_wdata, 0);
          r_data = mem_rd(cmd_addr); r_err = plan_lr_err; r_ok = 0; plan_lr_err = 0;
        end else begin
          chk("sc_wdata", cmd_wdata, exp_sc_wdata);
          chk("sc_wmask", cmd_wmask, 4'hF);
          r_data = $urandom;
          if (plan_sc_err) begin r_err = 1; r_ok = 0; plan_sc_err = 0; end
          else if (plan_fail > 0) begin r_err = 0; r_ok = 0; plan_fail--; end
          else begin r_err = 0; r_ok = 1; mem[cmd_addr] = cmd_wdata; end
        end
        pend = 1; dly = $urandom_range(0, 3);
      end
      @(posedge clk); #1;
      if (rst) begin pend = 0; irsp_valid = 0; end
      else if (rsp_hs) irsp_valid = 0;
      if (pend && !irsp_valid) begin
        if (dly == 0) begin
          irsp_valid = 1; irsp_err = r_err; irsp_ok = r_ok; irsp_rdata = r_data; pend = 0;
        end else dly--;
      end
      if (stray) begin
        irsp_valid = 1; irsp_err = 0; irsp_ok = 1; irsp_rdata = 32'hDEAD_BEEF;
      end else if (stray_was) irsp_valid = 0;
      stray_was = stray;
      cmd_ready = (hold_sc && cmd_valid && !cmd_read) ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Lock window and req_ready exclusivity.
  initial begin : protocol
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_valid || irsp_ready) chk("lock_in_sequence", cmd_lock, 1);
        if (req_ready || rsp_valid) chk("lock_outside_sequence", cmd_lock, 0);
        if (req_ready) chk("req_ready_only_idle", {cmd_valid, rsp_valid, irsp_ready}, 3'b000);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    logic [31:0] a, m, o;
    logic [2:0]  op;
    int          f;
    bit          le, se;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_lock", cmd_lock, 0);
    chk("rst_cmd_excl", cmd_excl, 0);
    chk("rst_icb_rsp_ready", irsp_ready, 0);
    @(posedge clk); #1; rst = 0;

    do_req(32'h100, OP_ADD, 32'd3, 32'd5, 0, 0, 0, 0);
    do_req(32'h104, OP_SWAP, 32'hCAFE_0001, 32'h1234_5678, 2, 0, 0, 0);
    do_req(32'h108, OP_ADD, 32'd1, 32'd9, 3, 0, 0, 0);
    do_req(32'h102, OP_ADD, 32'd1, 32'd0, 0, 0, 0, 1);
    do_req(32'h10C, OP_MIN, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    do_req(32'h10C, OP_MAXU, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    do_req(32'h10C, OP_MAX, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    do_req(32'h110, OP_ADD, 32'd1, 32'd2, 0, 1, 0, 0);
    do_req(32'h114, OP_ADD, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, 0);

    // Reset while the SC command is pending, then a stray response in IDLE.
    hold_sc = 1;
    mem[32'h200] = 32'd7; exp_addr = 32'h200; exp_sc_wdata = amo_ref(OP_ADD, 32'd7, 32'd1);
    plan_fail = 0; plan_lr_err = 0; plan_sc_err = 0;
    @(posedge clk); #1;
    req_valid = 1; req_addr = 32'h200; req_op = OP_ADD; req_wdata = 32'd1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 100);
    @(posedge clk); #1; req_valid = 0;
    t = 0;
    while (!(cmd_valid && !cmd_read) && t < 100) begin @(negedge clk); t++; end
    chk("reach_sc_cmd", cmd_valid && !cmd_read, 1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_mid_cmd_valid", cmd_valid, 0);
    chk("rst_mid_lock", cmd_lock, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    hold_sc = 0; cmd_count = 0; stray = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_rsp_not_accepted", irsp_ready, 0);
    end
    stray = 0;
    repeat (2) @(posedge clk);
    #1; cmd_count = 0;

    for (int i = 0; i < 40; i++) begin
      a  = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      op = 3'($urandom_range(0, 7));
      m  = $urandom;
      o  = $urandom;
      f  = $urandom_range(0, 3);
      le = ($urandom_range(0, 15) == 0);
      se = !le && ($urandom_range(0, 15) == 0);
      if (se) f = 0;
      do_req(a, op, o, m, f, le, se, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
